// File: rtl/pwm_fade_ctrl.sv
// LED breathing controller: a free-running PWM period counter plus a fade FSM that ramps the duty up, holds, ramps down, and holds.
// Define PWM_FADE_LOOP_EN to restart the ramp after the low hold instead of finishing with done_o.
module pwm_fade_ctrl #(
    parameter int PERIOD_CLKS  = 1002,
    parameter int STEP_PERIODS = 2,
    parameter int HOLD_PERIODS = 50,
    parameter int MAX_DUTY     = 100
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic [6:0] duty_cycle_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       period_tick_o
);

    localparam int CW      = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam int SUB_MAX = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
    localparam int SW      = $clog2(SUB_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_CLKS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [SW-1:0] HOLD_LAST = SW'(HOLD_PERIODS - 1);
    localparam logic [6:0]    MAX_D     = 7'(MAX_DUTY);

    typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [6:0]    duty_q, duty_d;
    logic          done_q, done_d;
    logic          tick;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            duty_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        sub_d   = sub_q;
        duty_d  = duty_q;
        done_d  = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
            sub_d   = '0;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    // Entry is mid-period; the first duty step still waits for a tick.
                    if (start_i) begin
                        state_d = RAMP_UP;
                        sub_d   = '0;
                    end
                end
                RAMP_UP: if (tick) begin
                    if (sub_q == STEP_LAST) begin
                        sub_d = '0;
                        if (duty_q < MAX_D) duty_d = duty_q + 7'd1;
                        if (duty_q >= MAX_D - 7'd1) state_d = HOLD_HI;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                HOLD_HI: begin
                    duty_d = MAX_D;
                    if (tick) begin
                        if (sub_q == HOLD_LAST) begin
                            state_d = RAMP_DOWN;
                            sub_d   = '0;
                        end else begin
                            sub_d = sub_q + 1'b1;
                        end
                    end
                end
                RAMP_DOWN: if (tick) begin
                    if (sub_q == STEP_LAST) begin
                        sub_d = '0;
                        if (duty_q != '0) duty_d = duty_q - 7'd1;
                        if (duty_q <= 7'd1) state_d = HOLD_LO;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                HOLD_LO: begin
                    duty_d = '0;
                    if (tick) begin
                        if (sub_q == HOLD_LAST) begin
                            sub_d = '0;
`ifdef PWM_FADE_LOOP_EN
                            state_d = RAMP_UP;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            sub_d = sub_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    sub_d   = '0;
                    duty_d  = '0;
                end
            endcase
        end
    end

    assign duty_cycle_o  = duty_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign period_tick_o = tick;

endmodule
